// File: rtl/axi_row_pkg.sv
// Shared widths, TDATA lane positions and FSM encoding for the row responder.
package axi_row_pkg;

  localparam int unsigned AXIS_DW    = 256;
  localparam int unsigned LANE_W     = 32;
  localparam int unsigned ROW_ID_LSB = 0;
  localparam int unsigned BEAT_LSB   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } row_state_e;

endpackage

// File: rtl/row_req_fifo.sv
// Request FIFO holding 32-bit row ids; extra pointer bit tells full from empty.
module row_req_fifo
  import axi_row_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [LANE_W-1:0] push_data,
  input  logic              pop,
  output logic [LANE_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [LANE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count    = CNT_W'(wr_ptr - rd_ptr);
  assign pop_data = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi_row_responder.sv
// Far end of the row-request stream: each queued request becomes one
// ROW_BEATS-beat row on the TX stream, with a completion pulse per row.
module axi_row_responder
  import axi_row_pkg::*;
#(
  parameter  int unsigned ROW_BEATS  = 32,
  parameter  int unsigned FIFO_DEPTH = 8,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AXIS_DW-1:0] AXIS_RX_TDATA,
  input  logic               AXIS_RX_TVALID,
  input  logic               AXIS_RX_TLAST,
  output logic               AXIS_RX_TREADY,
  output logic [AXIS_DW-1:0] AXIS_TX_TDATA,
  output logic               AXIS_TX_TVALID,
  output logic               AXIS_TX_TLAST,
  input  logic               AXIS_TX_TREADY,
  output logic               row_complete_out,
  output logic [CNT_W-1:0]   requests_pending,
  output logic [31:0]        rows_sent,
  output logic               idle_out
);

  localparam int unsigned        BEAT_W    = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(ROW_BEATS - 1);

  row_state_e        state;
  row_state_e        state_nxt;
  logic [LANE_W-1:0] row_id;
  logic [LANE_W-1:0] row_id_nxt;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_nxt;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LANE_W-1:0] fifo_data;
  logic [CNT_W-1:0]  fifo_count;

  logic              tx_fire;
  logic              last_beat;
  logic              row_done;
  logic              unused_rx;

  // Only the row id lane of a request matters; TLAST carries no meaning here.
  assign unused_rx = ^{AXIS_RX_TLAST, AXIS_RX_TDATA[AXIS_DW-1:LANE_W]};

  assign AXIS_RX_TREADY = ~reset & ~fifo_full;
  assign fifo_push      = AXIS_RX_TVALID & AXIS_RX_TREADY;

  row_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (AXIS_RX_TDATA[ROW_ID_LSB +: LANE_W]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign last_beat = (beat == LAST_BEAT);
  assign tx_fire   = (state == SEND) & AXIS_TX_TREADY;
  assign row_done  = tx_fire & last_beat;

  // Next-state: a finished row pops the next request in the same cycle.
  always_comb begin
    state_nxt  = state;
    row_id_nxt = row_id;
    beat_nxt   = beat;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          row_id_nxt = fifo_data;
          beat_nxt   = '0;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        if (row_done) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            row_id_nxt = fifo_data;
            beat_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (tx_fire) begin
          beat_nxt = beat + BEAT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      row_id           <= '0;
      beat             <= '0;
      row_complete_out <= 1'b0;
      rows_sent        <= '0;
    end else begin
      state            <= state_nxt;
      row_id           <= row_id_nxt;
      beat             <= beat_nxt;
      row_complete_out <= row_done;
      if (row_done) rows_sent <= rows_sent + 32'd1;
    end
  end

  // TX beat is a pure function of registered state, so it holds across stalls.
  always_comb begin
    AXIS_TX_TDATA = '0;
    if (state == SEND) begin
      AXIS_TX_TDATA[ROW_ID_LSB +: LANE_W] = row_id;
      AXIS_TX_TDATA[BEAT_LSB +: LANE_W]   = LANE_W'(beat);
    end
  end

  assign AXIS_TX_TVALID   = (state == SEND);
  assign AXIS_TX_TLAST    = (state == SEND) & last_beat;
  assign requests_pending = fifo_count;
  assign idle_out         = (state == IDLE) & fifo_empty;

endmodule

// File: tb/tb_axi_row_responder.sv
// Bench for axi_row_responder: a 32-beat and a 1-beat build driven in parallel,
// each compared every cycle against a queue-based request/row model.
module tb_axi_row_responder;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         rx_last = 1'b0;
  logic         tx_ready = 1'b0;

  logic [255:0] a_tdata, b_tdata;
  logic         a_tvalid, b_tvalid, a_tlast, b_tlast;
  logic         a_rx_ready, b_rx_ready, a_pulse, b_pulse, a_idle, b_idle;
  logic [3:0]   a_pend, b_pend;
  logic [31:0]  a_rows, b_rows;

  always #5 clk = ~clk;

  axi_row_responder #(.ROW_BEATS(32), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .reset(reset),
    .AXIS_RX_TDATA(rx_data), .AXIS_RX_TVALID(rx_valid), .AXIS_RX_TLAST(rx_last),
    .AXIS_RX_TREADY(a_rx_ready),
    .AXIS_TX_TDATA(a_tdata), .AXIS_TX_TVALID(a_tvalid), .AXIS_TX_TLAST(a_tlast),
    .AXIS_TX_TREADY(tx_ready),
    .row_complete_out(a_pulse), .requests_pending(a_pend), .rows_sent(a_rows),
    .idle_out(a_idle)
  );

  axi_row_responder #(.ROW_BEATS(1), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .reset(reset),
    .AXIS_RX_TDATA(rx_data), .AXIS_RX_TVALID(rx_valid), .AXIS_RX_TLAST(rx_last),
    .AXIS_RX_TREADY(b_rx_ready),
    .AXIS_TX_TDATA(b_tdata), .AXIS_TX_TVALID(b_tvalid), .AXIS_TX_TLAST(b_tlast),
    .AXIS_TX_TREADY(tx_ready),
    .row_complete_out(b_pulse), .requests_pending(b_pend), .rows_sent(b_rows),
    .idle_out(b_idle)
  );

  // Reference: queue of pending ids plus the row in flight.
  typedef struct packed {
    logic [7:0][31:0] q;
    int               qh;
    int               qn;
    bit               busy;
    logic [31:0]      id;
    int               beat;
    logic [31:0]      rows;
    bit               pulse;
  } model_t;

  typedef struct {
    int          n;
    logic [31:0] base;
    bit          rnd;
    int          exp_beats;
  } vec_t;

  model_t ma, mb;
  int     n_pass = 0;
  int     n_total = 0;
  bit     chk_en = 1'b0;
  int     a_beats, a_lasts, a_pulses, b_beats, b_lasts, b_pulses;

  function automatic model_t mstep(model_t m, int rb, bit rst, bit rv, logic [31:0] rd, bit tr);
    model_t n;
    bit     push;
    n = m;
    n.pulse = 1'b0;
    if (rst) return '0;
    push = rv && (m.qn < DEPTH);
    if (m.busy) begin
      if (tr) begin
        if (m.beat == rb - 1) begin
          n.pulse = 1'b1;
          n.rows  = m.rows + 32'd1;
          if (m.qn > 0) begin
            n.id   = m.q[m.qh];
            n.qh   = (m.qh + 1) % DEPTH;
            n.qn   = m.qn - 1;
            n.beat = 0;
          end else begin
            n.busy = 1'b0;
          end
        end else begin
          n.beat = m.beat + 1;
        end
      end
    end else if (m.qn > 0) begin
      n.busy = 1'b1;
      n.id   = m.q[m.qh];
      n.qh   = (m.qh + 1) % DEPTH;
      n.qn   = m.qn - 1;
      n.beat = 0;
    end
    if (push) begin
      n.q[(n.qh + n.qn) % DEPTH] = rd;
      n.qn = n.qn + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= mstep(ma, 32, reset, rx_valid, rx_data[31:0], tx_ready);
    mb <= mstep(mb, 1, reset, rx_valid, rx_data[31:0], tx_ready);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_dut(input string tag, input model_t m, input int rb,
                           input logic [255:0] td, input logic tv, input logic tl,
                           input logic rdy, input logic pl, input logic [3:0] pend,
                           input logic [31:0] rows, input logic idl);
    chk({tag, "_tvalid"}, 256'(tv), 256'(m.busy));
    if (m.busy) begin
      chk({tag, "_tdata"}, td, {192'd0, 32'(m.beat), m.id});
      chk({tag, "_tlast"}, 256'(tl), 256'(m.beat == rb - 1));
    end
    chk({tag, "_rx_ready"}, 256'(rdy), 256'(!reset && m.qn < DEPTH));
    chk({tag, "_pending"}, 256'(pend), 256'(m.qn));
    chk({tag, "_rows_sent"}, 256'(rows), 256'(m.rows));
    chk({tag, "_pulse"}, 256'(pl), 256'(m.pulse));
    chk({tag, "_idle"}, 256'(idl), 256'(!m.busy && m.qn == 0));
  endtask

  task automatic step();
    bit           a_hs, b_hs, a_l, b_l, stall;
    logic [255:0] prev_td;
    logic         prev_tl;
    a_hs    = a_tvalid && tx_ready && !reset;
    b_hs    = b_tvalid && tx_ready && !reset;
    a_l     = a_tlast;
    b_l     = b_tlast;
    stall   = a_tvalid && !tx_ready && !reset;
    prev_td = a_tdata;
    prev_tl = a_tlast;
    @(posedge clk);
    #1;
    if (a_hs) begin a_beats++; if (a_l) a_lasts++; end
    if (b_hs) begin b_beats++; if (b_l) b_lasts++; end
    if (a_pulse) a_pulses++;
    if (b_pulse) b_pulses++;
    if (chk_en) begin
      check_dut("a", ma, 32, a_tdata, a_tvalid, a_tlast, a_rx_ready, a_pulse, a_pend, a_rows, a_idle);
      check_dut("b", mb, 1, b_tdata, b_tvalid, b_tlast, b_rx_ready, b_pulse, b_pend, b_rows, b_idle);
      if (stall) begin
        chk("a_stall_tvalid", 256'(a_tvalid), 256'(1));
        chk("a_stall_tdata", a_tdata, prev_td);
        chk("a_stall_tlast", 256'(a_tlast), 256'(prev_tl));
      end
    end
  endtask

  task automatic clear_counts();
    a_beats = 0; a_lasts = 0; a_pulses = 0;
    b_beats = 0; b_lasts = 0; b_pulses = 0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_tdata", a_tdata, 256'(0));
    chk("rst_tvalid", 256'(a_tvalid), 256'(0));
    chk("rst_tlast", 256'(a_tlast), 256'(0));
    chk("rst_rx_ready", 256'(a_rx_ready), 256'(0));
    chk("rst_pending", 256'(a_pend), 256'(0));
    chk("rst_rows_sent", 256'(a_rows), 256'(0));
    chk("rst_idle", 256'(a_idle), 256'(1));
    reset = 1'b0;
    step();
    clear_counts();
  endtask

  task automatic send(input logic [31:0] id, input bit rnd, input int tries, output bit ok);
    rx_valid = 1'b1;
    rx_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, id};
    rx_last  = 1'($urandom_range(0, 1));
    ok = 1'b0;
    for (int t = 0; t < tries && !ok; t++) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      ok = a_rx_ready;
      step();
    end
    rx_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd, output bit done);
    done = 1'b0;
    for (int t = 0; t < 5000 && !done; t++) begin
      if (!ma.busy && ma.qn == 0 && !mb.busy && mb.qn == 0) begin
        done = 1'b1;
      end else begin
        tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
      end
    end
    tx_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[4];
    bit   ok, done, found;
    int   acc;

    vecs[0] = '{1, 32'h0000_C008, 1'b0, 32};
    vecs[1] = '{8, 32'h0000_C008, 1'b0, 256};
    vecs[2] = '{5, 32'h0000_A000, 1'b1, 160};
    vecs[3] = '{4, 32'h1234_5678, 1'b1, 128};

    // Table-driven rows: fixed and random downstream backpressure.
    foreach (vecs[v]) begin
      do_reset();
      tx_ready = 1'b1;
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].base + 32'(i), vecs[v].rnd, 200, ok);
        chk($sformatf("v%0d_accept%0d", v, i), 256'(ok), 256'(1));
      end
      drain(vecs[v].rnd, done);
      chk($sformatf("v%0d_drained", v), 256'(done), 256'(1));
      chk($sformatf("v%0d_a_beats", v), 256'(a_beats), 256'(vecs[v].exp_beats));
      chk($sformatf("v%0d_a_lasts", v), 256'(a_lasts), 256'(vecs[v].n));
      chk($sformatf("v%0d_a_pulses", v), 256'(a_pulses), 256'(vecs[v].n));
      chk($sformatf("v%0d_a_rows", v), 256'(a_rows), 256'(vecs[v].n));
      chk($sformatf("v%0d_a_idle", v), 256'(a_idle), 256'(1));
      chk($sformatf("v%0d_b_beats", v), 256'(b_beats), 256'(vecs[v].n));
      chk($sformatf("v%0d_b_lasts", v), 256'(b_lasts), 256'(vecs[v].n));
      chk($sformatf("v%0d_b_pulses", v), 256'(b_pulses), 256'(vecs[v].n));
    end

    // Fill with TX stalled: one row in flight, eight queued, tenth refused.
    do_reset();
    tx_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      send(32'hC100 + 32'(i), 1'b0, 3, ok);
      if (ok) acc++;
    end
    chk("fill_accepted", 256'(acc), 256'(9));
    chk("fill_pending", 256'(a_pend), 256'(8));
    chk("fill_rx_ready", 256'(a_rx_ready), 256'(0));
    chk("fill_b_pending", 256'(b_pend), 256'(8));
    tx_ready = 1'b1;
    send(32'hC109, 1'b0, 200, ok);
    chk("tenth_accepted", 256'(ok), 256'(1));
    chk("tenth_after_one_row", 256'(a_pulses), 256'(1));
    drain(1'b0, done);
    chk("fill_drained", 256'(done), 256'(1));
    chk("fill_rows", 256'(a_rows), 256'(10));

    // Reset in the middle of a row with three requests queued.
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(32'hC008 + 32'(i), 1'b0, 200, ok);
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      if (a_tvalid && a_tdata[63:32] == 32'd10) found = 1'b1;
      else step();
    end
    chk("mid_found_beat10", 256'(found), 256'(1));
    chk("mid_row_id", 256'(a_tdata[31:0]), 256'(32'hC008));
    chk("mid_pending", 256'(a_pend), 256'(3));
    reset = 1'b1;
    step();
    chk("mid_rst_tvalid", 256'(a_tvalid), 256'(0));
    chk("mid_rst_pending", 256'(a_pend), 256'(0));
    chk("mid_rst_pulse", 256'(a_pulse), 256'(0));
    chk("mid_rst_rows", 256'(a_rows), 256'(0));
    reset = 1'b0;
    step();
    clear_counts();
    send(32'hD000, 1'b0, 200, ok);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (a_tvalid) found = 1'b1;
      else step();
    end
    chk("post_rst_started", 256'(found), 256'(1));
    chk("post_rst_row_id", 256'(a_tdata[31:0]), 256'(32'hD000));
    chk("post_rst_beat0", 256'(a_tdata[63:32]), 256'(0));
    drain(1'b0, done);
    chk("post_rst_rows", 256'(a_rows), 256'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
